// File: rtl/traffic_light_pkg.sv
// Shared lamp-phase encoding and default phase lengths for the traffic-light
// controller and its receive-side monitor.
package traffic_light_pkg;

  // One-hot phase codes; identical to the controller's state_out encoding.
  typedef enum logic [3:0] {
    PH_ILLEGAL = 4'b0000,
    PH_OFF     = 4'b0001,
    PH_RED     = 4'b0010,
    PH_YELLOW  = 4'b0100,
    PH_GREEN   = 4'b1000
  } phase_e;

  localparam int unsigned DEF_RED_LEN    = 51;
  localparam int unsigned DEF_YELLOW_LEN = 11;
  localparam int unsigned DEF_GREEN_LEN  = 31;

  function automatic phase_e decode_lamps(input logic r, input logic y, input logic g);
    phase_e p;
    case ({r, y, g})
      3'b000:  p = PH_OFF;
      3'b100:  p = PH_RED;
      3'b010:  p = PH_YELLOW;
      3'b001:  p = PH_GREEN;
      default: p = PH_ILLEGAL;
    endcase
    return p;
  endfunction

  // Legality of a change between two distinct decoded phases.
  function automatic logic legal_change(input phase_e from, input phase_e to);
    logic ok;
    ok = 1'b0;
    if (from == PH_ILLEGAL || to == PH_ILLEGAL || to == PH_OFF)
      ok = 1'b1;
    else if ((from == PH_OFF    && to == PH_RED)    ||
             (from == PH_RED    && to == PH_YELLOW) ||
             (from == PH_YELLOW && to == PH_GREEN)  ||
             (from == PH_GREEN  && to == PH_RED))
      ok = 1'b1;
    return ok;
  endfunction

endpackage

// File: rtl/traffic_light_monitor.sv
// Passive checker for traffic-light lamp outputs: decodes the lamp triple,
// checks phase order and durations, and reports pulsed plus sticky errors.
module traffic_light_monitor
  import traffic_light_pkg::*;
#(
  parameter int unsigned RED_LEN    = DEF_RED_LEN,
  parameter int unsigned YELLOW_LEN = DEF_YELLOW_LEN,
  parameter int unsigned GREEN_LEN  = DEF_GREEN_LEN
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       red,
  input  logic       yellow,
  input  logic       green,
  input  logic       clr,
  output logic [3:0] phase_out,
  output logic [7:0] phase_cnt,
  output logic       seq_err,
  output logic       len_err,
  output logic       hot_err,
  output logic [2:0] err_sticky,
  output logic [7:0] cycles_done
);

  phase_e     phase_q, phase_d, sample;
  logic [7:0] cnt_q, cnt_d;
  logic       seq_q, seq_d, len_q, len_d, hot_q, hot_d;
  logic [2:0] sticky_q, sticky_d;
  logic [7:0] cycles_q, cycles_d;
  logic       ovr_q, ovr_d;
  logic [7:0] len_cur;
  logic       lit_cur;

  always_ff @(posedge clk) begin
    if (!reset) begin
      phase_q  <= PH_OFF;
      cnt_q    <= '0;
      seq_q    <= 1'b0;
      len_q    <= 1'b0;
      hot_q    <= 1'b0;
      sticky_q <= '0;
      cycles_q <= '0;
      ovr_q    <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      cnt_q    <= cnt_d;
      seq_q    <= seq_d;
      len_q    <= len_d;
      hot_q    <= hot_d;
      sticky_q <= sticky_d;
      cycles_q <= cycles_d;
      ovr_q    <= ovr_d;
    end
  end

  always_comb begin
    case (phase_q)
      PH_RED:    len_cur = 8'(RED_LEN);
      PH_YELLOW: len_cur = 8'(YELLOW_LEN);
      PH_GREEN:  len_cur = 8'(GREEN_LEN);
      default:   len_cur = '0;
    endcase
    lit_cur = (phase_q == PH_RED) || (phase_q == PH_YELLOW) || (phase_q == PH_GREEN);
  end

  always_comb begin
    sample   = decode_lamps(red, yellow, green);
    phase_d  = sample;
    cnt_d    = cnt_q;
    seq_d    = 1'b0;
    len_d    = 1'b0;
    hot_d    = (sample == PH_ILLEGAL);
    ovr_d    = ovr_q;
    cycles_d = cycles_q;

    if (sample == phase_q) begin
      cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
      // Overrun fires on the sample that would push the count past LEN, once.
      if (lit_cur && !ovr_q && cnt_q == len_cur) begin
        len_d = 1'b1;
        ovr_d = 1'b1;
      end
    end else begin
      cnt_d = 8'd1;
      ovr_d = 1'b0;
      if (!legal_change(phase_q, sample)) begin
        seq_d = 1'b1;
      end else begin
        if (lit_cur && sample != PH_OFF && sample != PH_ILLEGAL && !ovr_q && cnt_q < len_cur)
          len_d = 1'b1;
        if (phase_q == PH_GREEN && sample == PH_RED && cycles_q != 8'hFF)
          cycles_d = cycles_q + 8'd1;
      end
    end

    // A pulse in the same cycle as clr still leaves its bit set.
    sticky_d = (clr ? 3'b000 : sticky_q) | {hot_d, len_d, seq_d};
  end

  assign phase_out   = phase_q;
  assign phase_cnt   = cnt_q;
  assign seq_err     = seq_q;
  assign len_err     = len_q;
  assign hot_err     = hot_q;
  assign err_sticky  = sticky_q;
  assign cycles_done = cycles_q;

endmodule
